sort_exerciser: RTL and testbench
=================================

Name: sort_exerciser

Overview:
- Self-contained stimulus generator and result checker for the on-chip N-element 8-bit sorter. It drives the other end of the sorter's interface: dut_rst, dut_start and dut_data_in out; dut_data_out and dut_done in.
- Runs a programmable number of trials back-to-back, using LFSR-generated arrays.
- Each result is checked for non-decreasing order and for preserved contents (sum and XOR checksums).
- Reports pass/fail, the error class and the trial count.
- Used for FPGA bring-up and as the bench-side driver in regression.

Parameters:
- N, 8, number of array elements. Must match the sorter. N >= 2.
- SEED, 8'hA5, initial LFSR state. A value of 0 is replaced by 8'h01.
- TIMEOUT, 1024, maximum cycles in WAIT before a timeout failure is declared.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  start a campaign; sampled only in IDLE
- trials  in  16  number of trials per campaign; sampled with run
- dut_rst  out  1  one-cycle re-arm reset pulse to the sorter
- dut_start  out  1  one-cycle start pulse to the sorter
- dut_data_in  out  8 x N  generated array; held stable from LAUNCH through REPORT
- dut_data_out  in  8 x N  sorter result
- dut_done  in  1  sorter completion flag (level)
- busy  out  1  high in every state except IDLE and REPORT
- pass  out  1  campaign finished with no error; sticky until next run or rst
- fail  out  1  campaign aborted on an error; sticky until next run or rst
- err_code  out  2  0 = none, 1 = ORDER, 2 = CHECKSUM, 3 = TIMEOUT
- trial_count  out  16  number of trials completed successfully

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = SEED (or 8'h01 if SEED = 0); dut_data_in all 0; all counters 0.
- LFSR: 8-bit Fibonacci. next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. It advances once per generated element and persists across trials and campaigns. Only rst reloads the seed.
- IDLE:
  - When run = 1: clear pass, fail, err_code and trial_count; latch trials.
  - If latched trials = 0, set pass = 1 and go to REPORT.
  - Otherwise go to GEN.
  - run while busy is ignored.
- GEN (N cycles, index k = 0..N-1):
  - dut_data_in[k] <= lfsr, then the LFSR advances.
  - Accumulate sum_in (width 8 + clog2(N), no overflow possible) and xor_in.
  - After the last element, go to RESET_DUT.
- RESET_DUT (1 cycle): dut_rst = 1. Go to LAUNCH.
- LAUNCH (1 cycle): dut_start = 1. Clear the timeout counter. Go to WAIT.
- WAIT:
  - If dut_done = 1, go to CHECK with k = 0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set fail = 1 and err_code = 3, and go to REPORT.
  - dut_done sampled in the same cycle as LAUNCH is ignored.
- CHECK (N cycles, index k):
  - Accumulate sum_out and xor_out from dut_data_out[k].
  - For k > 0, if dut_data_out[k-1] > dut_data_out[k] (unsigned), flag ORDER.
  - At k = N-1:
    - If ORDER is flagged: err_code = 1, fail.
    - Else if sum_out != sum_in or xor_out != xor_in: err_code = 2, fail.
    - Otherwise trial_count++. If trial_count reaches latched trials, set pass = 1 and go to REPORT; else go to GEN.
  - ORDER takes priority over CHECKSUM.
- REPORT:
  - pass, fail and err_code are held.
  - run = 1 starts a new campaign with the same behaviour as from IDLE. REPORT otherwise behaves as IDLE.
- dut_start and dut_rst are registered, never asserted together, and each is high for exactly one cycle per trial.
- trial_count saturates at 16'hFFFF.
- rst during any state (mid-GEN, WAIT or CHECK): immediate return to reset values. No partial results are reported.
- Latency per trial = N (GEN) + 1 (RESET_DUT) + 1 (LAUNCH) + DUT latency + N (CHECK).

Test Plan:
- Reset, then dump the first GEN: dut_data_in[0..2] = 8'hA5, 8'h4A, 8'h95. All outputs 0 in the cycle after rst deasserts.
- Real sorter, N = 8, trials = 4, run pulse: exactly 4 dut_start pulses, each preceded one cycle earlier by a dut_rst pulse. Result: pass = 1, fail = 0, err_code = 0, trial_count = 4, busy low after completion.
- Pass-through model (dut_data_out = dut_data_in, dut_done asserted 3 cycles after start), trials = 1: 8'hA5 > 8'h4A, so fail = 1, err_code = 1, trial_count = 0.
- Model that sorts correctly but forces dut_data_out[0] = 8'h00, trials = 2: order still holds but the sum mismatches, so err_code = 2, fail = 1, trial_count = 0.
- Model that never asserts dut_done, TIMEOUT = 16: fail = 1 and err_code = 3 exactly 16 cycles after entering WAIT. No further dut_start pulses.
- Edge cases:
  - trials = 0 with run: pass = 1 the next cycle, no dut_start pulse.
  - run pulsed while busy: no effect.
  - rst asserted mid-WAIT: all outputs return to 0 asynchronously, and the next campaign regenerates 8'hA5 first.

Source files
------------

// File: rtl/sort_exerciser_if.sv
// Sorter-side bundle: re-arm/start pulses, array out,
// result array and done flag back from the sorter.
interface sort_exerciser_if #(
  parameter int N = 8
);
  logic                dut_rst;
  logic                dut_start;
  logic [N-1:0][7:0]   dut_data_in;
  logic [N-1:0][7:0]   dut_data_out;
  logic                dut_done;

  modport master (
    output dut_rst,
    output dut_start,
    output dut_data_in,
    input  dut_data_out,
    input  dut_done
  );

  modport slave (
    input  dut_rst,
    input  dut_start,
    input  dut_data_in,
    output dut_data_out,
    output dut_done
  );
endinterface

// File: rtl/sort_exerciser.sv
// LFSR-driven stimulus generator and result checker
// for the N-element 8-bit sorter.
module sort_exerciser #(
  parameter int          N       = 8,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter int          TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [15:0]   trials,
  sort_exerciser_if.master sif,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    err_code,
  output logic [15:0]   trial_count
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 8 + KW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SEED0 =
    (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [2:0] {
    IDLE, GEN, RESET_DUT, LAUNCH,
    WAIT, CHECK, REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [N-1:0][7:0] data_q, data_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     sin_q, sin_d;
  logic [SW-1:0]     sout_q, sout_d;
  logic [7:0]        xin_q, xin_d;
  logic [7:0]        xout_q, xout_d;
  logic              ord_q, ord_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       trials_q, trials_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [1:0]        err_q, err_d;
  logic              drst_q, dstart_q;

  logic [7:0]        lfsr_nx;
  logic [7:0]        cur, prv;
  logic [KW-1:0]     kp;
  logic              last;

  assign lfsr_nx = {lfsr_q[6:0],
    lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign last = (k_q == KW'(N - 1));
  assign kp   = (k_q == '0) ? '0 : k_q - KW'(1);
  assign cur  = sif.dut_data_out[k_q];
  assign prv  = sif.dut_data_out[kp];

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    data_d   = data_q;
    k_d      = k_q;
    sin_d    = sin_q;
    sout_d   = sout_q;
    xin_d    = xin_q;
    xout_d   = xout_q;
    ord_d    = ord_q;
    tmo_d    = tmo_q;
    trials_d = trials_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE, REPORT: begin
        if (run) begin
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          err_d    = 2'd0;
          cnt_d    = '0;
          trials_d = trials;
          if (trials == 16'd0) begin
            pass_d  = 1'b1;
            state_d = REPORT;
          end else begin
            state_d = GEN;
            k_d     = '0;
            sin_d   = '0;
            xin_d   = '0;
          end
        end
      end
      GEN: begin
        data_d[k_q] = lfsr_q;
        lfsr_d      = lfsr_nx;
        sin_d       = sin_q + SW'(lfsr_q);
        xin_d       = xin_q ^ lfsr_q;
        if (last) begin
          k_d     = '0;
          state_d = RESET_DUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      RESET_DUT: state_d = LAUNCH;
      LAUNCH: begin
        tmo_d   = '0;
        sout_d  = '0;
        xout_d  = '0;
        ord_d   = 1'b0;
        k_d     = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sif.dut_done) begin
          state_d = CHECK;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT)) begin
            fail_d  = 1'b1;
            err_d   = 2'd3;
            state_d = REPORT;
          end
        end
      end
      CHECK: begin
        sout_d = sout_q + SW'(cur);
        xout_d = xout_q ^ cur;
        ord_d  = ord_q | ((k_q != '0) && (prv > cur));
        if (last) begin
          if (ord_d) begin
            fail_d  = 1'b1;
            err_d   = 2'd1;
            state_d = REPORT;
          end else if (sout_d != sin_q ||
                       xout_d != xin_q) begin
            fail_d  = 1'b1;
            err_d   = 2'd2;
            state_d = REPORT;
          end else begin
            if (cnt_q != 16'hFFFF)
              cnt_d = cnt_q + 16'd1;
            if (cnt_d == trials_q) begin
              pass_d  = 1'b1;
              state_d = REPORT;
            end else begin
              state_d = GEN;
              k_d     = '0;
              sin_d   = '0;
              xin_d   = '0;
            end
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED0;
      data_q   <= '0;
      k_q      <= '0;
      sin_q    <= '0;
      sout_q   <= '0;
      xin_q    <= '0;
      xout_q   <= '0;
      ord_q    <= 1'b0;
      tmo_q    <= '0;
      trials_q <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= 2'd0;
      drst_q   <= 1'b0;
      dstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      data_q   <= data_d;
      k_q      <= k_d;
      sin_q    <= sin_d;
      sout_q   <= sout_d;
      xin_q    <= xin_d;
      xout_q   <= xout_d;
      ord_q    <= ord_d;
      tmo_q    <= tmo_d;
      trials_q <= trials_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      // pulses track the state they belong to
      drst_q   <= (state_d == RESET_DUT);
      dstart_q <= (state_d == LAUNCH);
    end
  end

  assign sif.dut_rst     = drst_q;
  assign sif.dut_start   = dstart_q;
  assign sif.dut_data_in = data_q;

  assign busy        = (state_q != IDLE) &&
                       (state_q != REPORT);
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_q;
  assign trial_count = cnt_q;
endmodule

// File: tb/tb_sort_exerciser.sv
// Directed bench for sort_exerciser with a
// mode-selectable behavioural sorter on the far side.
module tb_sort_exerciser;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] trials = '0;
  logic        busy, pass, fail;
  logic [1:0]  err_code;
  logic [15:0] trial_count;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  int nstart = 0;
  int nrst   = 0;
  int seqbad = 0;
  logic prev_rst = 1'b0;

  logic [N-1:0][7:0] mout;
  logic              mdone;
  logic              arm;
  int                lat;

  sort_exerciser_if #(.N(N)) sif ();

  sort_exerciser #(
    .N(N), .SEED(8'hA5), .TIMEOUT(16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .trials      (trials),
    .sif         (sif.master),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .err_code    (err_code),
    .trial_count (trial_count)
  );

  always #5 clk = ~clk;

  assign sif.dut_data_out = mout;
  assign sif.dut_done     = mdone;

  function automatic logic [N-1:0][7:0] model(
    input logic [N-1:0][7:0] a, input int m);
    logic [N-1:0][7:0] s;
    logic [7:0] t;
    s = a;
    if (m != 1) begin
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N - 1 - i; j++)
          if (s[j] > s[j+1]) begin
            t = s[j]; s[j] = s[j+1]; s[j+1] = t;
          end
    end
    if (m == 2) s[0] = 8'h00;
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mout <= '0; mdone <= 1'b0; arm <= 1'b0; lat <= 0;
    end else if (sif.dut_rst) begin
      mdone <= 1'b0; arm <= 1'b0;
    end else if (sif.dut_start) begin
      mout <= model(sif.dut_data_in, mode);
      arm  <= 1'b1;
      lat  <= 3;
    end else if (arm) begin
      if (lat == 1) begin
        arm   <= 1'b0;
        mdone <= (mode != 3);
      end
      lat <= lat - 1;
    end
  end

  always @(posedge clk) begin
    if (sif.dut_start) nstart <= nstart + 1;
    if (sif.dut_rst) nrst <= nrst + 1;
    if (sif.dut_start && !prev_rst) seqbad <= seqbad + 1;
    if (sif.dut_start && sif.dut_rst) seqbad <= seqbad + 1;
    prev_rst <= sif.dut_rst;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_run(input logic [15:0] t);
    @(negedge clk);
    trials = t;
    run    = 1'b1;
    @(negedge clk);
    run    = 1'b0;
  endtask

  // 0: dut_rst, 1: dut_start, 2: !busy, 3: fail
  task automatic wait_for(input int which, input int max,
                          input string tag, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = sif.dut_rst;
        1: hit = sif.dut_start;
        2: hit = !busy;
        default: hit = fail;
      endcase
    end
    if (!hit) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int n, s0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_err", err_code, 0);
    chk("rst_cnt", trial_count, 0);
    chk("rst_pulses", {sif.dut_rst, sif.dut_start}, 0);
    chk("rst_data", (sif.dut_data_in == '0), 1);

    // real sorter, 4 trials, stray run while busy
    mode = 0;
    s0 = nstart;
    pulse_run(16'd4);
    wait_for(0, 50, "to_gen1", n);
    chk("gen_d0", sif.dut_data_in[0], 8'hA5);
    chk("gen_d1", sif.dut_data_in[1], 8'h4A);
    chk("gen_d2", sif.dut_data_in[2], 8'h95);
    pulse_run(16'd1);
    wait_for(2, 2000, "to_pass", n);
    chk("ok_pass", pass, 1);
    chk("ok_fail", fail, 0);
    chk("ok_err", err_code, 0);
    chk("ok_cnt", trial_count, 4);
    chk("ok_busy", busy, 0);
    chk("ok_starts", nstart - s0, 4);
    chk("ok_seq", seqbad, 0);

    // pass-through: A5 before 4A breaks order
    do_reset();
    mode = 1;
    pulse_run(16'd1);
    wait_for(2, 500, "to_ord", n);
    chk("ord_fail", fail, 1);
    chk("ord_pass", pass, 0);
    chk("ord_err", err_code, 1);
    chk("ord_cnt", trial_count, 0);

    // sorted but element 0 zeroed: checksum error
    mode = 2;
    pulse_run(16'd2);
    wait_for(2, 500, "to_sum", n);
    chk("sum_fail", fail, 1);
    chk("sum_err", err_code, 2);
    chk("sum_cnt", trial_count, 0);

    // no done: 16 WAIT cycles, observed on the
    // 17th negedge after the LAUNCH negedge
    mode = 3;
    s0 = nstart;
    pulse_run(16'd1);
    wait_for(1, 50, "to_launch", n);
    wait_for(3, 100, "to_tmo", n);
    chk("tmo_cycles", n, 17);
    chk("tmo_err", err_code, 3);
    repeat (40) @(negedge clk);
    chk("tmo_starts", nstart - s0, 1);
    chk("tmo_busy", busy, 0);

    // zero trials
    s0 = nstart;
    pulse_run(16'd0);
    chk("zero_pass", pass, 1);
    chk("zero_busy", busy, 0);
    chk("zero_fail", fail, 0);
    repeat (5) @(negedge clk);
    chk("zero_starts", nstart - s0, 0);

    // rst mid-WAIT
    pulse_run(16'd1);
    wait_for(1, 50, "to_launch2", n);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_flags", {pass, fail, err_code}, 0);
    chk("arst_pulses", {sif.dut_rst, sif.dut_start}, 0);
    chk("arst_data", (sif.dut_data_in == '0), 1);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    pulse_run(16'd1);
    wait_for(0, 50, "to_gen2", n);
    chk("regen_d0", sif.dut_data_in[0], 8'hA5);
    wait_for(2, 500, "to_pass2", n);
    chk("regen_pass", pass, 1);
    chk("regen_cnt", trial_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
